ps2_teclado_rx: RTL and testbench

PS/2 keyboard receiver and interrupt source. It sits directly upstream of the PicoBlaze control wrapper.
- Deserialises PS/2 frames and filters out break sequences (F0 xx) and E0 prefixes.
- Queues make scan codes, then presents each one on an 8-bit port with a level interrupt.
- The PicoBlaze acknowledges each code through interrupt_ack.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_fifo.sv | 52 +++++
 rtl/ps2_teclado_rx.sv | 175 +++++++++++++++++
 tb/tb_ps2_teclado_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: protocol prefixes, frame FSM states and
// the scan codes the control program reacts to.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } frame_state_t;

    // Bits 0-7 data, 8 parity, 9 stop: odd parity over data+parity, stop high.
    function automatic logic frame_ok(input logic [9:0] f);
        return (^f[8:0]) && f[9];
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous make-code queue; pop is served first so a push into a full
// queue still lands when a pop happens in the same cycle, otherwise it is refused.
module ps2_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver: make codes are queued and offered to the PicoBlaze with a
// level interrupt, 3 cycles after the filtered stop-bit fall; a full queue drops codes.
module ps2_teclado_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYC    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       interrupt_ack,
    output logic [7:0] codigo,
    output logic       interrupt,
    output logic       overflow,
    output logic       error_trama
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    frame_state_t  state;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tocnt;
    logic          brk;
    logic          ext;
    logic          push_req;
    logic [7:0]    push_dat;
    logic [7:0]    rx_byte;

    logic          holding;
    logic [HW-1:0] hold_cnt;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    assign rx_byte = shreg[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            // A new level is only taken after FILTER_LEN consecutive differing samples.
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            tocnt       <= '0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            push_req    <= 1'b0;
            push_dat    <= '0;
            error_trama <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            error_trama <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fall && !data_sync[1]) begin
                        state  <= ST_RECV;
                        bitcnt <= '0;
                        tocnt  <= '0;
                    end
                end
                ST_RECV: begin
                    if (fall) begin
                        shreg  <= {data_sync[1], shreg[9:1]};
                        bitcnt <= bitcnt + 1'b1;
                        tocnt  <= '0;
                        if (bitcnt == 4'd9) state <= ST_CHECK;
                    end else if (tocnt == TO_LAST) begin
                        state       <= ST_IDLE;
                        error_trama <= 1'b1;
                    end else begin
                        tocnt <= tocnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (!frame_ok(shreg)) begin
                        error_trama <= 1'b1;
                    end else begin
                        // ext survives only across an F0; any other byte closes the sequence.
                        ext <= (rx_byte == PS2_EXT) || (ext && (rx_byte == PS2_BREAK));
                        if (rx_byte == PS2_BREAK) begin
                            brk <= 1'b1;
                        end else if (rx_byte != PS2_EXT) begin
                            brk <= 1'b0;
                            if (!brk) begin
                                push_req <= 1'b1;
                                push_dat <= rx_byte;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop       = holding && (hold_cnt == HW'(1));
    assign interrupt = !fifo_empty && !holding;
    assign codigo    = fifo_empty ? 8'h00 : fifo_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holding  <= 1'b0;
            hold_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && fifo_full && !pop;
            if (holding) begin
                if (hold_cnt == HW'(1)) begin
                    holding  <= 1'b0;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end else if (interrupt_ack && interrupt) begin
                holding  <= 1'b1;
                hold_cnt <= HOLD_LOAD;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Directed bench for ps2_teclado_rx; the PS/2 clock runs with a 20-cycle half
// period so the whole sequence fits in a short run.
module tb_ps2_teclado_rx;

    localparam int H    = 20;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       interrupt_ack = 1'b0;
    logic [7:0] codigo;
    logic       interrupt;
    logic       overflow;
    logic       error_trama;

    int total = 0;
    int passed = 0;
    int ov_cnt = 0;
    int err_cnt = 0;
    int lat;
    int e0;

    always #5 clk = ~clk;

    ps2_teclado_rx dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .interrupt_ack (interrupt_ack),
        .codigo        (codigo),
        .interrupt     (interrupt),
        .overflow      (overflow),
        .error_trama   (error_trama)
    );

    always @(negedge clk) begin
        if (overflow)    ov_cnt++;
        if (error_trama) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        @(negedge clk);
        ps2_data = d;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // lat = clk edges from the raw stop-bit fall until interrupt is seen high (-1: never).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, output int lat_o);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        lat_o = -1;
        for (int c = 1; c <= H; c++) begin
            @(posedge clk);
            #1;
            if (lat_o < 0 && interrupt) lat_o = c;
        end
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    // Ack the head, check it stays frozen for HOLD cycles (a second ack is ignored),
    // then check the next head appears.
    task automatic hold_ack(input string tag, input logic [7:0] cur, input logic [7:0] nxt);
        int bad;
        bad = 0;
        chk({tag, "_pre_int"}, interrupt, 1);
        chk({tag, "_pre_cod"}, codigo, cur);
        @(negedge clk);
        interrupt_ack = 1'b1;
        for (int c = 1; c <= HOLD; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 || c == 11) interrupt_ack = 1'b0;
            if (c == 10) interrupt_ack = 1'b1;
            if (codigo !== cur || interrupt !== 1'b0) bad++;
        end
        chk({tag, "_hold_bad"}, bad, 0);
        @(posedge clk);
        #1;
        chk({tag, "_post_cod"}, codigo, nxt);
        chk({tag, "_post_int"}, interrupt, (nxt != 8'h00));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_codigo", codigo, 8'h00);
        chk("rst_int", interrupt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", error_trama, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 2 sync + 8 filter samples + 3 cycles to interrupt = 13 edges
        send_frame(8'h1D, 1'b0, lat);
        chk("lat_1d", lat, 13);
        chk("cod_1d", codigo, 8'h1D);
        hold_ack("h1d", 8'h1D, 8'h00);

        send_frame(8'h1C, 1'b0, lat);
        send_frame(8'hF0, 1'b0, lat);
        send_frame(8'h1C, 1'b0, lat);
        hold_ack("brk", 8'h1C, 8'h00);

        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hF0, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        hold_ack("ext", 8'h75, 8'h00);
        chk("no_err_yet", err_cnt, 0);

        send_frame(8'h1D, 1'b0, lat);
        send_frame(8'h1B, 1'b0, lat);
        send_frame(8'h1C, 1'b0, lat);
        send_frame(8'h23, 1'b0, lat);
        chk("ovf_none", ov_cnt, 0);
        send_frame(8'h15, 1'b0, lat);
        chk("ovf_once", ov_cnt, 1);
        hold_ack("q0", 8'h1D, 8'h1B);
        hold_ack("q1", 8'h1B, 8'h1C);
        hold_ack("q2", 8'h1C, 8'h23);
        hold_ack("q3", 8'h23, 8'h00);

        e0 = err_cnt;
        send_frame(8'h1D, 1'b1, lat);
        chk("par_err", err_cnt, e0 + 1);
        chk("par_noint", interrupt, 0);

        // Start bit plus four data bits, then the clock stops.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        repeat (19950) @(negedge clk);
        chk("to_early", err_cnt, e0 + 1);
        repeat (100) @(negedge clk);
        chk("to_err", err_cnt, e0 + 2);
        chk("to_noint", interrupt, 0);
        send_frame(8'h1B, 1'b0, lat);
        chk("to_next_cod", codigo, 8'h1B);
        hold_ack("to", 8'h1B, 8'h00);

        send_frame(8'h1D, 1'b0, lat);
        chk("mid_pend", interrupt, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rrx_cod", codigo, 8'h00);
        chk("rrx_int", interrupt, 0);
        chk("rrx_ovf", overflow, 0);
        chk("rrx_err", error_trama, 0);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h23, 1'b0, lat);
        chk("rrx_lat", lat, 13);
        chk("rrx_new", codigo, 8'h23);
        chk("rrx_no_err", err_cnt, e0 + 2);

        @(negedge clk);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        repeat (10) @(negedge clk);
        chk("hld_int", interrupt, 0);
        chk("hld_cod", codigo, 8'h23);
        #2 reset = 1'b0;
        #1;
        chk("rhd_cod", codigo, 8'h00);
        chk("rhd_int", interrupt, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h1C, 1'b0, lat);
        chk("rhd_new", codigo, 8'h1C);
        hold_ack("fresh", 8'h1C, 8'h00);
        chk("end_err", err_cnt, e0 + 2);
        chk("end_ovf", ov_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
